// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: FSM encoding, default widths
// and the word-alignment helpers.
package mem_access_stage_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_REG_W  = 5;

    // Byte-offset bits that must be zero for a word access.
    localparam logic [1:0] WORD_OFFSET_MASK = 2'b11;

    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return (low_bits & WORD_OFFSET_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. Loads every cycle; a bubble clears RegWrite so the
// slot retires with no register-file update.
module mem_wb_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              bubble,
    input  logic [DATA_W-1:0] data_in,
    input  logic [REG_W-1:0]  reg_num_in,
    input  logic              reg_write_in,
    output logic [DATA_W-1:0] wb_data,
    output logic [REG_W-1:0]  wb_reg_num,
    output logic              wb_reg_write
);

    logic [DATA_W-1:0] data_reg;
    logic [REG_W-1:0]  reg_num_reg;
    logic              reg_write_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            data_reg      <= '0;
            reg_num_reg   <= '0;
            reg_write_reg <= 1'b0;
        end else begin
            data_reg      <= data_in;
            reg_num_reg   <= reg_num_in;
            reg_write_reg <= reg_write_in & ~bubble;
        end
    end

    assign wb_data      = data_reg;
    assign wb_reg_num   = reg_num_reg;
    assign wb_reg_write = reg_write_reg;

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: issues at most one outstanding data-memory access over a req/ack
// port, stalls upstream while it is in flight, and feeds the MEM/WB register.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int REG_W   = DEF_REG_W,
    parameter int TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [REG_W-1:0]  wr_reg_num,
    input  logic              reg_write,
    input  logic              mem_write,
    input  logic              mem_read,
    input  logic              mem_to_reg,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [DATA_W-1:0] wb_data,
    output logic [REG_W-1:0]  wb_reg_num,
    output logic              wb_reg_write,
    output logic              misalign,
    output logic              bus_err
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

    mem_state_t        state_reg, state_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic              dmem_req_reg, dmem_we_reg;
    logic [ADDR_W-1:0] dmem_addr_reg;
    logic [DATA_W-1:0] dmem_wdata_reg;
    logic              misalign_reg, bus_err_reg;

    logic              mem_op, misaligned;
    logic [ADDR_W-1:0] word_addr;
    logic              start_access, finish_access, abort_access, bubble;
    logic [DATA_W-1:0] wb_data_next;

    assign mem_op     = mem_read | mem_write;
    assign misaligned = mem_op & is_misaligned(alu_result[1:0]);
    assign word_addr  = ADDR_W'(alu_result) & ~ADDR_W'(WORD_OFFSET_MASK);

    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        stall         = 1'b0;
        start_access  = 1'b0;
        finish_access = 1'b0;
        abort_access  = 1'b0;
        bubble        = 1'b0;
        wb_data_next  = alu_result;
        case (state_reg)
            IDLE: begin
                if (mem_op && !misaligned) begin
                    stall        = 1'b1;
                    bubble       = 1'b1;
                    start_access = 1'b1;
                    count_next   = '0;
                    state_next   = BUSY;
                end else if (misaligned) begin
                    bubble = 1'b1;
                end
            end
            BUSY: begin
                if (dmem_ack) begin
                    finish_access = 1'b1;
                    state_next    = IDLE;
                    if (mem_to_reg) wb_data_next = dmem_rdata;
                end else if (count_reg == LAST_WAIT) begin
                    // Retire the instruction without writeback; upstream moves on.
                    abort_access = 1'b1;
                    bubble       = 1'b1;
                    state_next   = IDLE;
                end else begin
                    stall      = 1'b1;
                    bubble     = 1'b1;
                    count_next = count_reg + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            dmem_req_reg   <= 1'b0;
            dmem_we_reg    <= 1'b0;
            dmem_addr_reg  <= '0;
            dmem_wdata_reg <= '0;
            misalign_reg   <= 1'b0;
            bus_err_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            misalign_reg <= (state_reg == IDLE) && misaligned;
            if (start_access) begin
                dmem_req_reg   <= 1'b1;
                dmem_we_reg    <= mem_write;
                dmem_addr_reg  <= word_addr;
                dmem_wdata_reg <= rt_data;
            end else if (finish_access || abort_access) begin
                dmem_req_reg <= 1'b0;
            end
            if (abort_access) bus_err_reg <= 1'b1;
        end
    end

    assign dmem_req   = dmem_req_reg;
    assign dmem_we    = dmem_we_reg;
    assign dmem_addr  = dmem_addr_reg;
    assign dmem_wdata = dmem_wdata_reg;
    assign misalign   = misalign_reg;
    assign bus_err    = bus_err_reg;

    mem_wb_reg #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W)
    ) u_mem_wb_reg (
        .clock        (clock),
        .reset        (reset),
        .bubble       (bubble),
        .data_in      (wb_data_next),
        .reg_num_in   (wr_reg_num),
        .reg_write_in (reg_write),
        .wb_data      (wb_data),
        .wb_reg_num   (wb_reg_num),
        .wb_reg_write (wb_reg_write)
    );

endmodule
